prbs10_checker: RTL and testbench

- Serial PRBS checker directly downstream of the 10-bit LFSR pattern generator; consumes its 1-bit Data_out stream.
- Self-synchronises to the incoming sequence, declares lock, counts bit errors against a free-running local reference and drops lock on sustained errors.
- Used for on-chip BIST and link loopback checks.

---
 rtl/prbs10_checker.sv | 136 +++++++++++++
 tb/tb_prbs10_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs10_checker.sv
// rtl/prbs10_checker.sv - serial x^10+x^7+1 PRBS checker with self-sync, lock detection and error counting
module prbs10_checker #(
    parameter int TAP_A         = 10,
    parameter int TAP_B         = 7,
    parameter int LOCK_COUNT    = 16,
    parameter int WINDOW        = 64,
    parameter int UNLOCK_THRESH = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W = $clog2(TAP_A + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAP_A);
    localparam logic [8:0] LOCK_N   = 9'(LOCK_COUNT);
    localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);
    localparam logic [8:0] THRESH   = 9'(UNLOCK_THRESH);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [TAP_A-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [7:0]        match_cnt;
    logic [7:0]        win_cnt;
    logic [7:0]        win_err;

    logic       pred;
    logic       mismatch;
    logic       hist_zero;
    logic       hist_full;
    logic [8:0] match_next;
    logic [8:0] win_err_next;
    logic       lock_hit;
    logic       unlock_hit;

    assign pred         = hist[TAP_A-1] ^ hist[TAP_B-1];
    assign mismatch     = data_in ^ pred;
    assign hist_zero    = (hist == '0);
    assign hist_full    = (fill == FILL_MAX);
    assign match_next   = {1'b0, match_cnt} + 9'd1;
    assign win_err_next = {1'b0, win_err} + {8'd0, mismatch};
    assign lock_hit     = hist_full && !hist_zero && !mismatch && (match_next == LOCK_N);
    assign unlock_hit   = (win_err_next >= THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            error <= 1'b0;
            if (data_valid) begin
                case (state)
                    SEARCH: begin
                        hist <= {hist[TAP_A-2:0], data_in};
                        if (!hist_full) begin
                            fill <= fill + FILL_W'(1);
                        end
                        if (hist_full) begin
                            // An all-zero history is a stuck generator or dead line, never a match.
                            if (hist_zero || mismatch) begin
                                match_cnt <= '0;
                            end else if (lock_hit) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                win_cnt   <= '0;
                                win_err   <= '0;
                            end else begin
                                match_cnt <= match_next[7:0];
                            end
                        end
                    end
                    LOCKED: begin
                        // Free-running reference: one corrupted input bit is charged only once.
                        hist  <= {hist[TAP_A-2:0], pred};
                        error <= mismatch;
                        if (unlock_hit) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            hist      <= '0;
                            fill      <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 8'd1;
                            win_err <= win_err_next[7:0];
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end

            if (clear_counts) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (data_valid && state == LOCKED) begin
                bit_count <= sat_inc(bit_count);
                if (mismatch) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs10_checker.sv
// tb/tb_prbs10_checker.sv - scoreboard bench for prbs10_checker against a queue-based sequence model
module tb_prbs10_checker;

    localparam int LOCK_COUNT = 16;
    localparam int WINDOW     = 64;
    localparam int THRESH     = 8;
    localparam int SAT_BIG    = 65535;
    localparam int SAT_SMALL  = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b0;
    logic data_valid = 1'b0;
    logic clear_counts = 1'b0;

    logic        locked, error;
    logic [15:0] err_count, bit_count;
    logic        locked_s, error_s;
    logic [3:0]  err_count_s, bit_count_s;

    always #5 clock = ~clock;

    prbs10_checker #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_counts(clear_counts), .locked(locked), .error(error),
        .err_count(err_count), .bit_count(bit_count)
    );

    prbs10_checker #(.CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_counts(clear_counts), .locked(locked_s), .error(error_s),
        .err_count(err_count_s), .bit_count(bit_count_s)
    );

    typedef struct {
        bit lk;
        bit er;
        int errs;
        int bits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: last ten bits as a queue, oldest first.
    bit m_locked, m_error;
    int m_errs, m_bits;
    bit hq[$];
    int run, win_pos, win_errs;

    // Generator: s[n] = s[n-10] ^ s[n-7], first ten bits taken from the seed.
    bit         gq[$];
    int         gpos = 0;
    logic [9:0] seed = 10'h001;

    task automatic check(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== 32'(req)) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic gen_next(output bit b);
        if (gpos < 10) b = seed[gpos];
        else b = gq[0] ^ gq[3];
        gq.push_back(b);
        if (gq.size() > 10) void'(gq.pop_front());
        gpos++;
    endtask

    task automatic model_reset();
        m_locked = 0; m_error = 0; m_errs = 0; m_bits = 0;
        hq.delete(); run = 0; win_pos = 0; win_errs = 0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit clr);
        bit p, nz;
        m_error = 0;
        if (v) begin
            if (!m_locked) begin
                if (hq.size() == 10) begin
                    p = hq[0] ^ hq[3];
                    nz = 0;
                    foreach (hq[i]) nz |= hq[i];
                    if (!nz || d != p) run = 0;
                    else run++;
                    void'(hq.pop_front());
                end
                hq.push_back(d);
                if (run == LOCK_COUNT) begin
                    m_locked = 1; run = 0; win_pos = 0; win_errs = 0;
                end
            end else begin
                p = hq[0] ^ hq[3];
                void'(hq.pop_front());
                hq.push_back(p);
                if (m_bits < SAT_BIG) m_bits++;
                if (d != p) begin
                    m_error = 1;
                    if (m_errs < SAT_BIG) m_errs++;
                    win_errs++;
                end
                if (win_errs >= THRESH) begin
                    m_locked = 0; hq.delete(); run = 0; win_pos = 0; win_errs = 0;
                end else if (win_pos == WINDOW - 1) begin
                    win_pos = 0; win_errs = 0;
                end else begin
                    win_pos++;
                end
            end
        end
        if (clr) begin
            m_errs = 0; m_bits = 0;
        end
    endtask

    task automatic drive(input bit d, input bit v, input bit clr);
        exp_t e;
        data_in = d; data_valid = v; clear_counts = clr;
        model_step(d, v, clr);
        e.lk = m_locked; e.er = m_error; e.errs = m_errs; e.bits = m_bits;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic send_gen(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            drive(b, 1'b1, 1'b0);
        end
    endtask

    task automatic send_err();
        bit b;
        gen_next(b);
        drive(~b, 1'b1, 1'b0);
    endtask

    task automatic align_window();
        while (win_pos != 0) send_gen(1);
    endtask

    task automatic async_reset_check(input string tag);
        data_valid = 0; clear_counts = 0;
        #2 reset = 0;
        #1;
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_bit_count"}, 32'(bit_count), 0);
        model_reset();
        @(negedge clock);
        #1 reset = 1;
        @(negedge clock);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_locked", 32'(locked), int'(e.lk));
                check("sb_error", 32'(error), int'(e.er));
                check("sb_err_count", 32'(err_count), e.errs);
                check("sb_bit_count", 32'(bit_count), e.bits);
                check("sb_err_count_sat", 32'(err_count_s), (e.errs > SAT_SMALL) ? SAT_SMALL : e.errs);
                check("sb_bit_count_sat", 32'(bit_count_s), (e.bits > SAT_SMALL) ? SAT_SMALL : e.bits);
                check("sb_locked_small", 32'(locked_s), int'(e.lk));
            end
        end
    end

    initial begin : stimulus
        bit b, v, c;
        model_reset();
        repeat (3) @(negedge clock);
        #1;
        check("reset_locked", 32'(locked), 0);
        check("reset_error", 32'(error), 0);
        check("reset_err_count", 32'(err_count), 0);
        check("reset_bit_count", 32'(bit_count), 0);
        reset = 1;
        @(negedge clock);
        #1;

        send_gen(25);
        check("lock_not_before_26", 32'(locked), 0);
        send_gen(1);
        check("lock_at_26", 32'(locked), 1);
        send_gen(300);
        check("clean_bit_count", 32'(bit_count), 300);
        check("clean_err_count", 32'(err_count), 0);

        send_err();
        check("single_err_pulse", 32'(error), 1);
        check("single_err_count", 32'(err_count), 1);
        send_gen(1);
        check("single_err_pulse_end", 32'(error), 0);
        check("single_err_locked", 32'(locked), 1);
        send_gen(20);
        check("single_err_no_more", 32'(err_count), 1);

        drive(1'b0, 1'b0, 1'b1);
        align_window();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("unlock_not_before_8th", 32'(locked), 1);
            send_err();
            if (k < 7) send_gen(2);
        end
        check("unlock_on_8th", 32'(locked), 0);
        check("unlock_err_count", 32'(err_count), 8);
        send_gen(25);
        check("relock_not_before_26", 32'(locked), 0);
        send_gen(1);
        check("relock_at_26", 32'(locked), 1);

        drive(1'b0, 1'b0, 1'b1);
        align_window();
        for (int k = 0; k < 7; k++) begin send_err(); send_gen(1); end
        align_window();
        for (int k = 0; k < 7; k++) begin send_err(); send_gen(1); end
        send_gen(5);
        check("split_windows_locked", 32'(locked), 1);
        check("split_windows_err_count", 32'(err_count), 14);

        async_reset_check("midlock_reset");
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0);
        check("dead_line_locked", 32'(locked), 0);
        check("dead_line_bit_count", 32'(bit_count), 0);

        send_gen(40);
        check("relock_after_dead", 32'(locked), 1);
        gen_next(b);
        drive(~b, 1'b1, 1'b1);
        check("clear_beats_error_count", 32'(err_count), 0);
        check("clear_error_pulse", 32'(error), 1);
        drive(1'b1, 1'b0, 1'b0);
        check("hold_invalid_bits", 32'(bit_count), 0);

        for (int i = 0; i < 3000; i++) begin
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 199) == 0);
            if (v) begin
                gen_next(b);
                if ($urandom_range(0, 39) == 0) b = ~b;
                drive(b, 1'b1, c);
            end else begin
                drive(1'($urandom_range(0, 1)), 1'b0, c);
            end
        end

        send_gen(60);
        check("final_locked_pre_reset", 32'(locked), 1);
        async_reset_check("final_reset");
        @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
